// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Fetch-side PC sequencer driven by the EX-stage branch unit and the hazard
//   unit. Owns the architectural PC and advances it by +4, holds it on a
//   load-use stall, redirects it on a taken branch/jump, and freezes it on halt.
//   Raises the IF/ID and ID/EX flush strobes that kill wrong-path instructions.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active-high
//   PcSel        in   redirect request (taken branch or jump)
//   BrPC         in   redirect target, meaningful when PcSel=1
//   Halt         in   halt request from the EX-stage instruction
//   Stall        in   load-use stall, hold PC
//   Cur_PC       out  current fetch address (registered)
//   IfId_Flush   out  zero the IF/ID register this cycle
//   IdEx_Flush   out  zero the ID/EX register this cycle
//   Halted       out  core halted, sticky until reset
//   Target_Err   out  sticky: redirect target misaligned or out of range
//   Redirect_Cnt out  accepted redirects, saturating
module pc_fetch_ctrl #(
  parameter int unsigned     PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     FLUSH_CYC = 1,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             Halt,
  input  logic             Stall,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             IfId_Flush,
  output logic             IdEx_Flush,
  output logic             Halted,
  output logic             Target_Err,
  output logic [CNT_W-1:0] Redirect_Cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_e;

  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_flush, idex_flush;
  logic             good_tgt;

  // Target must be word aligned and fit inside the PC address space.
  assign good_tgt = (BrPC[1:0] == 2'b00) && ((BrPC >> PC_W) == 32'd0);

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (state_q == S_HALT) begin
      ifid_flush = 1'b1;
    end else begin
      // Bubble countdown; any event below may override the next state.
      if (state_q == S_FLUSH) begin
        ifid_flush = 1'b1;
        if (fcnt_q > 3'd1) begin
          fcnt_d = fcnt_q - 3'd1;
        end else begin
          fcnt_d  = '0;
          state_d = S_RUN;
        end
      end

      if (Halt) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted_d   = 1'b1;
        state_d    = S_HALT;
      end else if (PcSel) begin
        // The redirecting instruction's younger neighbours are flushed even
        // when the target is bad; a stall in the same cycle is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (good_tgt) begin
          pc_d = BrPC[PC_W-1:0];
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (FLUSH_CYC > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_RELOAD;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          terr_d   = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
      end else if (!Stall) begin
        pc_d = pc_q + PC_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      fcnt_q   <= '0;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      terr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      terr_q   <= terr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flush strobes are combinational from the inputs and must stay low in reset.
  assign IfId_Flush   = ifid_flush & ~reset;
  assign IdEx_Flush   = idex_flush & ~reset;
  assign Cur_PC       = pc_q;
  assign Halted       = halted_q;
  assign Target_Err   = terr_q;
  assign Redirect_Cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: two instances share the stimulus. Instance A uses
// the default parameters; instance B uses FLUSH_CYC=3 and a 2-bit counter.
// Each expected record says which instance it applies to.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = '0;
  logic        Halt = 1'b0;
  logic        Stall = 1'b0;

  logic [8:0]  pc_a, pc_b;
  logic        ifid_a, ifid_b, idex_a, idex_b;
  logic        hal_a, hal_b, terr_a, terr_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  pc_fetch_ctrl #(.PC_W(9), .RESET_PC(9'h000), .FLUSH_CYC(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt), .Stall(Stall),
    .Cur_PC(pc_a), .IfId_Flush(ifid_a), .IdEx_Flush(idex_a), .Halted(hal_a),
    .Target_Err(terr_a), .Redirect_Cnt(cnt_a)
  );

  pc_fetch_ctrl #(.PC_W(9), .RESET_PC(9'h000), .FLUSH_CYC(3), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Halt(Halt), .Stall(Stall),
    .Cur_PC(pc_b), .IfId_Flush(ifid_b), .IdEx_Flush(idex_b), .Halted(hal_b),
    .Target_Err(terr_b), .Redirect_Cnt(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        sel;
    logic [8:0]  pc;
    logic        ifid;
    logic        idex;
    logic        hal;
    logic        terr;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vid = 0;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic sel, input logic rst, input logic pcsel,
                     input logic [31:0] br, input logic halt, input logic stall,
                     input logic [8:0] pc, input logic ifid, input logic idex,
                     input logic hal, input logic terr, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; PcSel = pcsel; BrPC = br; Halt = halt; Stall = stall;
    e.id = vid; e.sel = sel; e.pc = pc; e.ifid = ifid; e.idex = idex;
    e.hal = hal; e.terr = terr; e.cnt = cnt;
    q.push_back(e);
    vid++;
  endtask

  // Monitor: every output sample point with a queued expectation is checked.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [8:0]  apc;
      logic        aif, aid, ah, at;
      logic [15:0] ac;
      e = q.pop_front();
      if (e.sel) begin
        apc = pc_b; aif = ifid_b; aid = idex_b; ah = hal_b; at = terr_b; ac = {14'd0, cnt_b};
      end else begin
        apc = pc_a; aif = ifid_a; aid = idex_a; ah = hal_a; at = terr_a; ac = cnt_a;
      end
      n_vec++;
      if (apc !== e.pc || aif !== e.ifid || aid !== e.idex || ah !== e.hal ||
          at !== e.terr || ac !== e.cnt) begin
        n_err++;
        $display("FAIL vec%0d dut%s: got pc=%h ifid=%b idex=%b halted=%b terr=%b cnt=%0d want pc=%h ifid=%b idex=%b halted=%b terr=%b cnt=%0d",
                 e.id, e.sel ? "B" : "A", apc, aif, aid, ah, at, ac,
                 e.pc, e.ifid, e.idex, e.hal, e.terr, e.cnt);
      end
    end
  end

  initial begin
    // ---- instance A (FLUSH_CYC=1) ----
    //   sel rst pcs br        hlt stl  pc      if id hal te cnt
    cyc(0, 1, 1, 32'h040, 0, 0, 9'h000, 0, 0, 0, 0, 16'd0); // reset masks flushes
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h000, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h004, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h008, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h00C, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 1, 32'h040, 0, 0, 9'h010, 1, 1, 0, 0, 16'd0); // redirect to 0x40
    cyc(0, 0, 1, 32'h080, 0, 1, 9'h040, 1, 1, 0, 0, 16'd1); // redirect beats stall
    cyc(0, 0, 0, 32'h000, 0, 1, 9'h080, 0, 0, 0, 0, 16'd2); // stall holds
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h080, 0, 0, 0, 0, 16'd2);
    cyc(0, 0, 1, 32'h042, 0, 0, 9'h084, 1, 1, 0, 0, 16'd2); // misaligned target
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h084, 1, 0, 1, 1, 16'd2);
    cyc(0, 0, 1, 32'h100, 0, 0, 9'h084, 1, 0, 1, 1, 16'd2); // PcSel ignored in HALT
    cyc(0, 1, 0, 32'h000, 0, 0, 9'h000, 0, 0, 0, 0, 16'd0); // async reset from HALT
    cyc(0, 0, 1, 32'h200, 0, 0, 9'h000, 1, 1, 0, 0, 16'd0); // out-of-range target
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h000, 1, 0, 1, 1, 16'd0);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h000, 1, 0, 1, 1, 16'd0);
    cyc(0, 1, 0, 32'h000, 0, 0, 9'h000, 0, 0, 0, 0, 16'd0);
    cyc(0, 0, 1, 32'h1FC, 0, 0, 9'h000, 1, 1, 0, 0, 16'd0);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h1FC, 0, 0, 0, 0, 16'd1);
    cyc(0, 0, 0, 32'h000, 0, 0, 9'h000, 0, 0, 0, 0, 16'd1); // wrapped
    cyc(0, 0, 1, 32'h040, 1, 0, 9'h004, 1, 1, 0, 0, 16'd1); // Halt beats PcSel
    cyc(0, 0, 1, 32'h040, 0, 0, 9'h004, 1, 0, 1, 0, 16'd1);
    cyc(0, 0, 0, 32'h000, 1, 1, 9'h004, 1, 0, 1, 0, 16'd1);
    // ---- instance B (FLUSH_CYC=3, CNT_W=2) ----
    cyc(1, 1, 0, 32'h000, 0, 0, 9'h000, 0, 0, 0, 0, 16'd0);
    cyc(1, 0, 1, 32'h020, 0, 0, 9'h000, 1, 1, 0, 0, 16'd0);
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h020, 1, 0, 0, 0, 16'd1);
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h024, 1, 0, 0, 0, 16'd1);
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h028, 0, 0, 0, 0, 16'd1);
    cyc(1, 0, 1, 32'h040, 0, 0, 9'h02C, 1, 1, 0, 0, 16'd1);
    cyc(1, 0, 1, 32'h060, 0, 0, 9'h040, 1, 1, 0, 0, 16'd2); // reload mid-flush
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h060, 1, 0, 0, 0, 16'd3);
    cyc(1, 0, 0, 32'h000, 0, 1, 9'h064, 1, 0, 0, 0, 16'd3); // stall during flush
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h064, 0, 0, 0, 0, 16'd3);
    cyc(1, 0, 1, 32'h080, 0, 0, 9'h068, 1, 1, 0, 0, 16'd3); // counter saturates
    cyc(1, 0, 0, 32'h000, 1, 0, 9'h080, 1, 1, 0, 0, 16'd3); // Halt in FLUSH
    cyc(1, 0, 0, 32'h000, 0, 0, 9'h080, 1, 0, 1, 0, 16'd3);
    cyc(1, 0, 1, 32'h020, 0, 0, 9'h080, 1, 0, 1, 0, 16'd3);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
